// File: rtl/riscv_bus_pkg.sv
// Shared types and constants for the core-side memory bus.
package riscv_bus_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } bus_state_e;

endpackage

// File: rtl/arb_prio_sel.sv
// Fetch/data winner select with a starvation counter that forces a fetch grant
// after FETCH_STARVE_MAX consecutive data grants made while fetch was waiting.
module arb_prio_sel #(
    parameter int FETCH_STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_arb_en,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_if_req_raw,
    input  logic i_ls_req,
    output logic o_grant_if,
    output logic o_grant_ls
);

    localparam logic [3:0] STARVE_MAX = 4'(FETCH_STARVE_MAX);

    logic [3:0] r_starve_cnt;
    logic       w_force_if;

    assign w_force_if = i_if_req && (r_starve_cnt == STARVE_MAX);
    assign o_grant_ls = i_arb_en && i_ls_req && !w_force_if;
    assign o_grant_if = i_arb_en && i_if_req && !o_grant_ls;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (o_grant_if) begin
            r_starve_cnt <= '0;
        end else if (o_grant_ls && i_if_req_raw) begin
            if (r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end else if (i_idle && !i_if_req_raw) begin
            r_starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction fetch and load/store, sequencing
// each transfer through launch, wait-state hold, completion and optional timeout.
module mem_bus_arbiter
    import riscv_bus_pkg::*;
#(
    parameter int FETCH_STARVE_MAX = 4,
    parameter int BUS_TIMEOUT      = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_done,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [2:0]      ls_size,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_done,
    input  logic            flush,
    output logic            bus_req,
    output logic            bus_we,
    output logic [2:0]      bus_size,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_ready,
    output logic            bus_timeout
);

    bus_state_e r_state;
    logic [7:0] r_wait_cnt;
    logic       r_flush_seen;

    logic       w_idle;
    logic       w_arb_en;
    logic       w_if_req_m;
    logic       w_ls_req_m;
    logic       w_grant_if;
    logic       w_grant_ls;
    logic [8:0] w_wait_nxt;
    logic       w_timeout_hit;
    logic       w_fetch_drop;

    // A done cycle is a turnaround cycle: no new grant until the pulse has gone.
    assign w_idle        = (r_state == ST_IDLE);
    assign w_arb_en      = w_idle && !if_done && !ls_done;
    assign w_if_req_m    = if_req && !flush && !if_done;
    assign w_ls_req_m    = ls_req && !ls_done;
    assign w_wait_nxt    = {1'b0, r_wait_cnt} + 9'd1;
    assign w_timeout_hit = (BUS_TIMEOUT != 0) && (w_wait_nxt == 9'(BUS_TIMEOUT));
    assign w_fetch_drop  = flush || r_flush_seen;

    arb_prio_sel #(
        .FETCH_STARVE_MAX(FETCH_STARVE_MAX)
    ) u_arb_prio_sel (
        .clk         (clk),
        .reset       (reset),
        .i_arb_en    (w_arb_en),
        .i_idle      (w_idle),
        .i_if_req    (w_if_req_m),
        .i_if_req_raw(if_req),
        .i_ls_req    (w_ls_req_m),
        .o_grant_if  (w_grant_if),
        .o_grant_ls  (w_grant_ls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_flush_seen <= 1'b0;
            if_rdata     <= '0;
            if_done      <= 1'b0;
            ls_rdata     <= '0;
            ls_done      <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_size     <= '0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_timeout  <= 1'b0;
        end else begin
            if_done     <= 1'b0;
            ls_done     <= 1'b0;
            bus_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_grant_ls) begin
                        r_state   <= ST_DATA;
                        bus_req   <= 1'b1;
                        bus_we    <= ls_we;
                        bus_size  <= ls_size;
                        bus_addr  <= ls_addr;
                        bus_wdata <= ls_wdata;
                    end else if (w_grant_if) begin
                        r_state      <= ST_FETCH;
                        r_flush_seen <= 1'b0;
                        bus_req      <= 1'b1;
                        bus_we       <= 1'b0;
                        bus_size     <= HSIZE_WORD;
                        bus_addr     <= if_addr;
                        bus_wdata    <= '0;
                    end
                end
                ST_FETCH, ST_DATA: begin
                    if (r_state == ST_FETCH && flush)
                        r_flush_seen <= 1'b1;
                    // bus_ready takes precedence over a coincident timeout
                    if (bus_ready || w_timeout_hit) begin
                        r_state     <= ST_IDLE;
                        bus_req     <= 1'b0;
                        bus_we      <= 1'b0;
                        bus_timeout <= !bus_ready;
                        if (r_state == ST_DATA) begin
                            ls_done  <= 1'b1;
                            ls_rdata <= bus_ready ? bus_rdata : '0;
                        end else if (!w_fetch_drop) begin
                            if_done  <= 1'b1;
                            if_rdata <= bus_ready ? bus_rdata : '0;
                        end
                    end else begin
                        r_wait_cnt <= w_wait_nxt[7:0];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
